// File: rtl/timer_pkg.sv
// Shared register offsets and control-bit positions for the timer peripheral.
package timer_pkg;

    localparam logic [7:0] TIMER_CTRL  = 8'h00;
    localparam logic [7:0] TIMER_PRESC = 8'h02;
    localparam logic [7:0] TIMER_CMP   = 8'h04;
    localparam logic [7:0] TIMER_CNT   = 8'h06;
    localparam logic [7:0] TIMER_STAT  = 8'h08;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_IE      = 2;
    localparam int CTRL_W       = 3;

endpackage

// File: rtl/timer_prescaler.sv
// Programmable clock divider: emits a one-cycle tick every presc+1 enabled clocks.
// The tick is decoded from the registered count, so it lines up with the edge
// on which the count wraps back to 0.
module timer_prescaler
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] presc,
    input  logic        clear,
    output logic        tick
);

    logic [15:0] count;
    logic        at_end;

    assign at_end = (count == presc);
    // A PRESC rewrite restarts the period, so a tick on that edge is dropped.
    assign tick   = en & at_end & ~clear;

    // Count enabled clocks; disabled or cleared holds the count at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 16'h0000;
        end else if (!en || clear || at_end) begin
            count <= 16'h0000;
        end else begin
            count <= count + 16'h0001;
        end
    end

endmodule

// File: rtl/timer.sv
// Memory-mapped 16-bit timer/counter with prescaler, compare match,
// one-shot mode and a level interrupt. Every bus access takes two cycles:
// ready and read data are registered, writes commit on the ready cycle.
module timer
    import timer_pkg::*;
#(
    parameter logic [15:0] RESET_PRESC = 16'h0000,
    parameter logic [15:0] RESET_CMP   = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timer_valid,
    input  logic        timer_wstrb,
    input  logic [7:0]  timer_addr,
    input  logic [15:0] timer_wdata,
    output logic        timer_ready,
    output logic [15:0] timer_rdata,
    output logic        timer_irq
);

    logic [CTRL_W-1:0] ctrl;
    logic [15:0]       presc;
    logic [15:0]       cmp;
    logic [15:0]       cnt;
    logic              match;
    logic              tick;
    logic              hit;
    logic              wr_en;
    logic              wr_ctrl;
    logic              wr_presc;
    logic              wr_cmp;
    logic              wr_cnt;
    logic              wr_stat;
    logic [15:0]       rd_mux;

    assign wr_en    = timer_valid & timer_ready & timer_wstrb;
    assign wr_ctrl  = wr_en & (timer_addr == TIMER_CTRL);
    assign wr_presc = wr_en & (timer_addr == TIMER_PRESC);
    assign wr_cmp   = wr_en & (timer_addr == TIMER_CMP);
    assign wr_cnt   = wr_en & (timer_addr == TIMER_CNT);
    assign wr_stat  = wr_en & (timer_addr == TIMER_STAT);

    assign hit       = tick & (cnt == cmp);
    assign timer_irq = match & ctrl[CTRL_IE];

    timer_prescaler u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (ctrl[CTRL_EN]),
        .presc (presc),
        .clear (wr_presc),
        .tick  (tick)
    );

    // Read-data selection; unmapped offsets return 0.
    always_comb begin
        rd_mux = 16'h0000;
        case (timer_addr)
            TIMER_CTRL:  rd_mux = {13'h0000, ctrl};
            TIMER_PRESC: rd_mux = presc;
            TIMER_CMP:   rd_mux = cmp;
            TIMER_CNT:   rd_mux = cnt;
            TIMER_STAT:  rd_mux = {15'h0000, match};
            default:     rd_mux = 16'h0000;
        endcase
    end

    // Bus response: ready pulses the cycle after valid, never twice in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_ready <= 1'b0;
            timer_rdata <= 16'h0000;
        end else if (timer_valid && !timer_ready) begin
            timer_ready <= 1'b1;
            timer_rdata <= rd_mux;
        end else begin
            timer_ready <= 1'b0;
            timer_rdata <= 16'h0000;
        end
    end

    // Register file and counter; bus writes are placed last so they win.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl  <= '0;
            presc <= RESET_PRESC;
            cmp   <= RESET_CMP;
            cnt   <= 16'h0000;
            match <= 1'b0;
        end else begin
            if (tick) begin
                if (hit) begin
                    match <= 1'b1;
                    cnt   <= 16'h0000;
                    if (ctrl[CTRL_ONESHOT]) begin
                        ctrl[CTRL_EN] <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + 16'h0001;
                end
            end
            if (wr_ctrl) begin
                ctrl <= timer_wdata[CTRL_W-1:0];
            end
            if (wr_presc) begin
                presc <= timer_wdata;
            end
            if (wr_cmp) begin
                cmp <= timer_wdata;
            end
            if (wr_cnt) begin
                cnt <= timer_wdata;
            end
            // A match landing on the same edge as the clear keeps MATCH set.
            if (wr_stat && timer_wdata[0] && !hit) begin
                match <= 1'b0;
            end
        end
    end

endmodule
